// File: rtl/sm_seq_driver_pkg.sv
// Shared types for the serial detector sequencer: FSM state encoding.
package sm_seq_driver_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_SHIFT = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/sm_piso.sv
// Parallel-in serial-out shifter; msb is the next bit to be played.
module sm_piso #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         shift_en,
   output logic         msb
);

   logic [W-1:0] sr_q;
   logic [W-1:0] sr_d;

   always_comb begin
      sr_d = sr_q;
      if (load)
         sr_d = load_val;
      else if (shift_en)
         sr_d = {sr_q[W-2:0], 1'b0};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sr_q <= '0;
      else     sr_q <= sr_d;
   end

   assign msb = sr_q[W-1];

endmodule

// File: rtl/sm_seq_driver.sv
// Plays a captured bit pattern MSB-first into a serial detector and counts its hits.
module sm_seq_driver
   import sm_seq_driver_pkg::*;
#(
   parameter int unsigned MAX_LEN   = 16,
   parameter int unsigned LEN_W     = 5,
   parameter int unsigned CNT_W     = 5,
   parameter int unsigned DRAIN_CYC = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   len,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   hit_cnt,
   output logic               det_x,
   output logic               det_clr,
   input  logic               det_y
);

   localparam int unsigned DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [CNT_W-1:0] HIT_MAX = '1;

   state_e               state_q, state_d;
   logic [LEN_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [DRAIN_W-1:0]   drain_q, drain_d;
   logic [CNT_W-1:0]     hit_q, hit_d;
   logic                 first_q, first_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 det_x_q, det_x_d;
   logic                 det_clr_q, det_clr_d;

   logic [LEN_W-1:0]     len_eff;
   logic [MAX_LEN-1:0]   load_val;
   logic                 piso_load, piso_shift, piso_msb;
   logic                 count_en;

   // Left-justify the pattern so its first bit sits at the shifter MSB.
   assign len_eff  = (32'(len) > MAX_LEN) ? LEN_W'(MAX_LEN) : len;
   assign load_val = pattern << (LEN_W'(MAX_LEN) - len_eff);

   sm_piso #(.W(MAX_LEN)) u_piso (
      .clk      (clk),
      .rst      (rst),
      .load     (piso_load),
      .load_val (load_val),
      .shift_en (piso_shift),
      .msb      (piso_msb)
   );

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      drain_d    = drain_q;
      hit_d      = hit_q;
      first_d    = 1'b0;
      det_x_d    = 1'b0;
      piso_load  = 1'b0;
      piso_shift = 1'b0;

      // det_y lags det_x by one cycle, so the window skips the first SHIFT cycle.
      count_en = ((state_q == S_SHIFT) && !first_q) || (state_q == S_DRAIN);
      if (count_en && det_y && (hit_q != HIT_MAX))
         hit_d = hit_q + CNT_W'(1);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               piso_load = 1'b1;
               bit_cnt_d = len_eff;
               hit_d     = '0;
               state_d   = (len_eff != '0) ? S_CLEAR : S_DONE;
            end
         end
         S_CLEAR: begin
            state_d    = S_SHIFT;
            first_d    = 1'b1;
            det_x_d    = piso_msb;
            piso_shift = 1'b1;
            bit_cnt_d  = bit_cnt_q - LEN_W'(1);
         end
         S_SHIFT: begin
            if (bit_cnt_q == '0) begin
               state_d = S_DRAIN;
               drain_d = DRAIN_W'(DRAIN_CYC - 1);
            end else begin
               det_x_d    = piso_msb;
               piso_shift = 1'b1;
               bit_cnt_d  = bit_cnt_q - LEN_W'(1);
            end
         end
         S_DRAIN: begin
            if (drain_q == '0) state_d = S_DONE;
            else               drain_d = drain_q - DRAIN_W'(1);
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Status outputs are registered copies of what the next state implies.
      busy_d    = (state_d == S_CLEAR) || (state_d == S_SHIFT) || (state_d == S_DRAIN);
      done_d    = (state_d == S_DONE);
      det_clr_d = (state_d == S_CLEAR);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         drain_q   <= '0;
         hit_q     <= '0;
         first_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         det_x_q   <= 1'b0;
         det_clr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         drain_q   <= drain_d;
         hit_q     <= hit_d;
         first_q   <= first_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         det_x_q   <= det_x_d;
         det_clr_q <= det_clr_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign hit_cnt = hit_q;
   assign det_x   = det_x_q;
   assign det_clr = det_clr_q;

endmodule
